// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: two-way traffic-light sequencer (main road A, side road B).
// Holds a 1 s tick prescaler, the phase FSM with a per-phase countdown and
// a latched side-road request that keeps A green until B traffic shows up.
// Optional feature: define SEMAFORO_NIGHT_EN to add the `night` input and
// a flashing-yellow NIGHT state.
module semaforo_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int T_GREEN  = 7,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_b,
`ifdef SEMAFORO_NIGHT_EN
  input  logic       night,
`endif
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic [2:0] time_digit,
  output logic       tick
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED2  = 3'd5
`ifdef SEMAFORO_NIGHT_EN
    ,
    NIGHT = 3'd6
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          adv;
`ifdef SEMAFORO_NIGHT_EN
  logic          blink_q, blink_d;
`endif

  // Prescaler wraps at TICK_DIV-1; tick is the registered wrap strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PMAX) ? '0 : presc_q + 1'b1;
      tick_q  <= (presc_q == PMAX);
    end
  end

  // Phase state, countdown and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_GRN;
      cnt_q   <= 3'(T_GREEN);
      req_q   <= 1'b0;
`ifdef SEMAFORO_NIGHT_EN
      blink_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
`ifdef SEMAFORO_NIGHT_EN
      blink_q <= blink_d;
`endif
    end
  end

  // Next-state logic: count down on ticks, advance when the count is spent.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q | car_b;
    adv     = tick_q && (cnt_q == 3'd0);
`ifdef SEMAFORO_NIGHT_EN
    blink_d = 1'b1;
`endif
    if (tick_q && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
    case (state_q)
      A_GRN: begin
        // Without a side-road request A green is held with the count at 0.
        if (adv && req_q) begin
          state_d = A_YEL;
          cnt_d   = 3'(T_YELLOW);
        end
      end
      A_YEL: if (adv) begin state_d = RED1;  cnt_d = 3'(T_RED);    end
      RED1:  if (adv) begin state_d = B_GRN; cnt_d = 3'(T_GREEN);  end
      B_GRN: if (adv) begin state_d = B_YEL; cnt_d = 3'(T_YELLOW); end
      B_YEL: if (adv) begin state_d = RED2;  cnt_d = 3'(T_RED);    end
      RED2:  if (adv) begin state_d = A_GRN; cnt_d = 3'(T_GREEN);  end
`ifdef SEMAFORO_NIGHT_EN
      NIGHT: begin
        cnt_d   = 3'd0;
        blink_d = tick_q ? ~blink_q : blink_q;
        // Leaving night goes through all-red so B gets the next green.
        if (!night) begin
          state_d = RED1;
          cnt_d   = 3'(T_RED);
        end
      end
`endif
      default: begin
        state_d = A_GRN;
        cnt_d   = 3'(T_GREEN);
      end
    endcase
`ifdef SEMAFORO_NIGHT_EN
    if (night) begin
      state_d = NIGHT;
      cnt_d   = 3'd0;
    end
`endif
    // Entering B green serves the request; this wins over a same-cycle car_b.
    if ((state_d == B_GRN) && (state_q != B_GRN)) begin
      req_d = 1'b0;
    end
  end

  // Moore lamp decode from the current state only.
  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    case (state_q)
      A_GRN:   light_a = LAMP_GRN;
      A_YEL:   light_a = LAMP_YEL;
      B_GRN:   light_b = LAMP_GRN;
      B_YEL:   light_b = LAMP_YEL;
`ifdef SEMAFORO_NIGHT_EN
      NIGHT: begin
        light_a = blink_q ? LAMP_YEL : LAMP_OFF;
        light_b = blink_q ? LAMP_YEL : LAMP_OFF;
      end
`endif
      default: begin
        light_a = LAMP_RED;
        light_b = LAMP_RED;
      end
    endcase
  end

  assign time_digit = cnt_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Testbench for semaforo_ctrl: table-driven phase checks plus hand-written
// sequences for the request-driven cycle, async reset and short phases.
module tb_semaforo_ctrl;

  localparam int TD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       car_b = 1'b0;
  logic       car2  = 1'b1;
  logic [2:0] la, lb, dg, la2, lb2, dg2;
  logic       tk, tk2;
`ifdef SEMAFORO_NIGHT_EN
  logic       night = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int since  = 0;

  always #5 clk = ~clk;

  semaforo_ctrl #(.TICK_DIV(TD), .T_GREEN(7), .T_YELLOW(2), .T_RED(1)) dut (
    .clk(clk), .rst_n(rst_n), .car_b(car_b),
`ifdef SEMAFORO_NIGHT_EN
    .night(night),
`endif
    .light_a(la), .light_b(lb), .time_digit(dg), .tick(tk)
  );

  semaforo_ctrl #(.TICK_DIV(TD), .T_GREEN(7), .T_YELLOW(0), .T_RED(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .car_b(car2),
`ifdef SEMAFORO_NIGHT_EN
    .night(night),
`endif
    .light_a(la2), .light_b(lb2), .time_digit(dg2), .tick(tk2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for the next tick pulse, then one more cycle so its effect is visible.
  task automatic tick_step(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!tk && g < 50);
      if (!tk) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: got no tick in %0d cycles expected tick", g);
      end
      @(negedge clk);
    end
  endtask

  // Continuous checks: tick spacing and lamp safety on every cycle.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      since = 0;
    end else begin
      since++;
      if (tk) begin
        chk("tick_period", since, TD);
        since = 0;
      end
      chk("onehot_a", 32'($onehot(la)), 1);
      chk("onehot_b", 32'($onehot(lb)), 1);
      chk("one_red", 32'(la[2] | lb[2]), 1);
      chk("onehot_a2", 32'($onehot(la2)), 1);
      chk("one_red2", 32'(la2[2] | lb2[2]), 1);
    end
  end

  typedef struct {
    logic       car;
    int         n;
    logic [2:0] ea;
    logic [2:0] eb;
    logic [2:0] ed;
  } vec_t;

  vec_t tbl[13];

  logic [2:0] pa[6];
  logic [2:0] pb[6];
  logic [2:0] pd[6];
  int         plen[6];

  initial begin
    int g;
    int n;
    logic [5:0] code0;

    tbl[0]  = '{1'b0, 1, 3'b001, 3'b100, 3'd6};
    tbl[1]  = '{1'b0, 5, 3'b001, 3'b100, 3'd1};
    tbl[2]  = '{1'b0, 1, 3'b001, 3'b100, 3'd0};
    tbl[3]  = '{1'b0, 3, 3'b001, 3'b100, 3'd0};
    tbl[4]  = '{1'b1, 1, 3'b010, 3'b100, 3'd2};
    tbl[5]  = '{1'b0, 2, 3'b010, 3'b100, 3'd0};
    tbl[6]  = '{1'b0, 1, 3'b100, 3'b100, 3'd1};
    tbl[7]  = '{1'b0, 2, 3'b100, 3'b001, 3'd7};
    tbl[8]  = '{1'b0, 8, 3'b100, 3'b010, 3'd2};
    tbl[9]  = '{1'b0, 3, 3'b100, 3'b100, 3'd1};
    tbl[10] = '{1'b0, 2, 3'b001, 3'b100, 3'd7};
    tbl[11] = '{1'b0, 7, 3'b001, 3'b100, 3'd0};
    tbl[12] = '{1'b0, 4, 3'b001, 3'b100, 3'd0};

    pa = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    pb = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    pd = '{3'd2, 3'd1, 3'd7, 3'd2, 3'd1, 3'd7};
    plen = '{3, 2, 8, 3, 2, 8};

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_a", la, 3'b001);
    chk("rst_b", lb, 3'b100);
    chk("rst_digit", dg, 3'd7);
    chk("rst_tick", tk, 0);
    rst_n = 1'b1;

    // Countdown, hold, single request pulse, one full B cycle, hold again.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].car) begin
        car_b = 1'b1;
        @(negedge clk);
        car_b = 1'b0;
      end
      tick_step(tbl[i].n);
      chk($sformatf("v%0d_a", i), la, tbl[i].ea);
      chk($sformatf("v%0d_b", i), lb, tbl[i].eb);
      chk($sformatf("v%0d_digit", i), dg, tbl[i].ed);
    end

    // Continuous demand: leave the hold on the next tick, then time each phase.
    car_b = 1'b1;
    g = 0;
    do begin
      tick_step(1);
      g++;
    end while (la != 3'b010 && g < 20);
    chk("hold_exit_ticks", g, 1);
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("ph%0d_a", p), la, pa[p]);
      chk($sformatf("ph%0d_b", p), lb, pb[p]);
      chk($sformatf("ph%0d_digit", p), dg, pd[p]);
      code0 = {la, lb};
      n = 0;
      do begin
        tick_step(1);
        n++;
      end while ({la, lb} == code0 && n < 20);
      chk($sformatf("ph%0d_len", p), n, plen[p]);
    end

    // Walk into B yellow, then assert reset between ticks.
    car_b = 1'b0;
    tick_step(13);
    chk("byel_a", la, 3'b100);
    chk("byel_b", lb, 3'b010);
    chk("byel_digit", dg, 3'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", la, 3'b001);
    chk("arst_b", lb, 3'b100);
    chk("arst_digit", dg, 3'd7);
    chk("arst_tick", tk, 0);
    chk("arst_digit2", dg2, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset run; second instance has zero-length yellow and all-red.
    tick_step(1);
    chk("post_digit", dg, 3'd6);
    chk("post_digit2", dg2, 3'd6);
    tick_step(7);
    chk("post_hold_a", la, 3'b001);
    chk("post_hold_digit", dg, 3'd0);
    chk("short_yel_a", la2, 3'b010);
    chk("short_yel_b", lb2, 3'b100);
    chk("short_yel_digit", dg2, 3'd0);
    tick_step(1);
    chk("short_red_a", la2, 3'b100);
    chk("short_red_b", lb2, 3'b100);
    chk("short_red_digit", dg2, 3'd0);
    tick_step(1);
    chk("short_bgrn_a", la2, 3'b100);
    chk("short_bgrn_b", lb2, 3'b001);
    chk("short_bgrn_digit", dg2, 3'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_ctrl.md
Name: semaforo_ctrl

Overview:
Two-way traffic-light sequencer for the intersection: main road A and side road B. Holds the phase FSM, a second-tick prescaler and a per-phase countdown. Drives both lamp sets and a 3-bit remaining-time digit that feeds the 7-segment decoder directly. A latched side-road vehicle request extends A green until B traffic is present.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick; must be >= 2
T_GREEN, 7, green countdown start value (0..7)
T_YELLOW, 2, yellow countdown start value (0..7)
T_RED, 1, all-red clearance countdown start value (0..7)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous reset, active-low
car_b  in  1  side-road vehicle sensor, synchronous to clk, level
light_a  out  3  road A lamps {red,yellow,green}, one-hot
light_b  out  3  road B lamps {red,yellow,green}, one-hot
time_digit  out  3  remaining seconds in current phase, to display decoder
tick  out  1  one-cycle pulse each second

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - state=A_GRN, cnt=T_GREEN, prescaler=0, req=0, tick=0
  - light_a=001, light_b=100, time_digit=T_GREEN
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is registered; high for exactly the cycle after the prescaler reaches TICK_DIV-1.
- FSM states, cycled in order: A_GRN -> A_YEL -> RED1 -> B_GRN -> B_YEL -> RED2 -> A_GRN.
- Lamps are Moore outputs decoded from state only:
  - A_GRN: a=001, b=100
  - A_YEL: a=010, b=100
  - RED1 and RED2: a=100, b=100
  - B_GRN: a=100, b=001
  - B_YEL: a=100, b=010
- Countdown:
  - On every tick, if cnt != 0 then cnt decrements.
  - If cnt == 0, the FSM advances and cnt loads the next state's start value: GRN->T_GREEN, YEL->T_YELLOW, RED->T_RED.
  - Each phase lasts start+1 ticks. Start value 0 gives a 1-tick phase.
  - No action between ticks.
- time_digit = cnt at all times. It never exceeds 7; cnt is 3 bits.
- Request latch:
  - req sets on any cycle with car_b=1.
  - req clears on the transition into B_GRN.
  - If car_b=1 in that same cycle, clear wins; req re-sets on the next cycle car_b is high.
- A_GRN extension: when cnt==0 on a tick and req==0, stay in A_GRN with cnt held at 0. Leave on the first tick where req==1.
- Mid-operation reset: immediate return to reset values, regardless of state or prescaler phase.
- No unreachable-state lockup: any illegal state encoding goes to A_GRN with cnt=T_GREEN on the next clk.
- Parameter legality (T_* > 7, TICK_DIV < 2) is not checked in RTL.

Optional Feature:
- Macro: SEMAFORO_NIGHT_EN
- When defined:
  - Adds input port night (1 bit, level).
  - While night=1, the FSM is forced to state NIGHT:
    - light_a and light_b = 010 on even ticks, 000 on odd ticks. Toggle register flips each tick and resets to "on".
    - time_digit=0.
  - On night falling, enter RED1 with cnt=T_RED, so the cycle resumes with B_GRN.
  - req is still latched during NIGHT.
- When undefined:
  - No night port, no NIGHT state.
  - Behaviour is exactly as above.

Test Plan:
- Reset, TICK_DIV=4, defaults, car_b=0 -> light_a=001, light_b=100, time_digit=7. tick every 4 clk. Digit reaches 0 after 7 ticks and then holds 0/A_GRN indefinitely.
- From the held state, pulse car_b for 1 clk -> next tick: light_a=010, digit=2. After 3 ticks: RED1, both 100, digit=1. After 2 more ticks: B_GRN, light_b=001, digit=7. req reads 0.
- Full cycle with car_b=1 constant -> phase durations in ticks 8,3,2,8,3,2 repeating. Lamps are never green or yellow on both roads at once. Lamp vectors are always one-hot.
- T_YELLOW=0, T_RED=0 -> yellow and all-red each last exactly 1 tick, with digit=0 during each.
- Assert rst_n low mid-B_YEL, between ticks -> outputs return to reset values in the same cycle, asynchronously. After release, the first tick arrives TICK_DIV cycles later.
- With SEMAFORO_NIGHT_EN defined: night=1 during B_GRN -> both lamps alternate 010/000 per tick, digit=0. Drop night -> RED1 with digit=1, then B_GRN.
